// File: rtl/demux1to8_b32_buf.sv
// One-to-eight word demux with a 1-deep holding register per lane.
// The destination lane comes from an explicit index or from a round-robin pointer.
module demux1to8_b32_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2:0]           in_sel_i,
    input  logic [WIDTH-1:0]     in_data_i,
    input  logic                 auto_en_i,
    input  logic                 clr_ptr_i,
    output logic [2:0]           ptr_o,
    output logic [7:0]           out_valid_o,
    output logic [8*WIDTH-1:0]   out_data_o,
    input  logic [7:0]           out_ack_i,
    output logic                 all_full_o
);

    localparam int unsigned LANES = 8;
    localparam int unsigned PW    = 3;

    logic [LANES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [LANES];
    logic [WIDTH-1:0] data_d [LANES];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    tgt;
    logic             accept;

    // Ready is a function of the target lane only, never of in_valid_i.
    always_comb begin
        tgt        = auto_en_i ? ptr_q : in_sel_i;
        in_ready_o = ~valid_q[tgt] | out_ack_i[tgt];
        accept     = in_valid_i & in_ready_o;
    end

    // Acks drain lanes; an accept reloads its target even when that lane is acked this cycle.
    always_comb begin
        valid_d = valid_q & ~out_ack_i;
        for (int unsigned k = 0; k < LANES; k++) begin
            data_d[k] = data_q[k];
        end
        ptr_d = ptr_q;
        if (accept) begin
            valid_d[tgt] = 1'b1;
            data_d[tgt]  = in_data_i;
        end
        if (clr_ptr_i) begin
            ptr_d = '0;
        end else if (accept && auto_en_i) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ptr_q   <= '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            for (int unsigned k = 0; k < LANES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            out_data_o[WIDTH*k +: WIDTH] = data_q[k];
        end
    end

    assign out_valid_o = valid_q;
    assign ptr_o       = ptr_q;
    assign all_full_o  = &valid_q;

endmodule

// File: tb/tb_demux1to8_b32_buf.sv
// Scoreboard bench for demux1to8_b32_buf: a lane-occupancy model predicts ready/valid/ptr,
// per-lane queues hold expected words, and a negedge monitor compares.
module tb_demux1to8_b32_buf;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2:0]     in_sel = '0;
    logic [W-1:0]   in_data = '0;
    logic           auto_en = 1'b0;
    logic           clr_ptr = 1'b0;
    logic [2:0]     ptr;
    logic [7:0]     out_valid;
    logic [8*W-1:0] out_data;
    logic [7:0]     out_ack = '0;
    logic           all_full;

    demux1to8_b32_buf #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_sel_i(in_sel),
        .in_data_i(in_data), .auto_en_i(auto_en), .clr_ptr_i(clr_ptr),
        .ptr_o(ptr), .out_valid_o(out_valid), .out_data_o(out_data),
        .out_ack_i(out_ack), .all_full_o(all_full)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: which lanes hold a word, the pointer, and the words expected per lane.
    logic [W-1:0] exp_q [8][$];
    logic [7:0]   m_full = '0;
    int           m_ptr = 0;
    logic [7:0]   s_valid = '0;
    int           s_ptr = 0;
    bit           s_ready = 1'b1;
    bit           mon_en = 1'b0;
    bit           hold_v = 1'b0;
    logic [W-1:0] hold_d = '0;
    logic [2:0]   hold_s = '0;

    task automatic check(string nm, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] lane(int k);
        return out_data[W*k +: W];
    endfunction

    // Drive one cycle of inputs and advance the model by the same cycle.
    task automatic drive(bit v, logic [2:0] sel, logic [W-1:0] d, bit au, bit clr, logic [7:0] ack);
        int  t;
        bit  acc;
        @(posedge clk);
        #1;
        if (hold_v)
            assert (v && d == hold_d && sel == hold_s)
                else $error("FAIL producer_hold: stalled word was changed or withdrawn");
        in_valid = v; in_sel = sel; in_data = d; auto_en = au; clr_ptr = clr; out_ack = ack;
        s_valid = m_full;
        s_ptr   = m_ptr;
        t       = au ? m_ptr : int'(sel);
        s_ready = !m_full[t] || ack[t];
        acc     = v && s_ready;
        if (acc) exp_q[t].push_back(d);
        m_full = m_full & ~ack;
        if (acc) m_full[t] = 1'b1;
        if (clr) m_ptr = 0;
        else if (acc && au) m_ptr = (m_ptr + 1) % 8;
        hold_v = v && !acc;
        hold_d = d;
        hold_s = sel;
        mon_en = 1'b1;
    endtask

    task automatic idle(bit clr, logic [7:0] ack);
        drive(1'b0, 3'd0, '0, 1'b0, clr, ack);
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        mon_en = 1'b0;
        in_valid = 1'b0; out_ack = '0; clr_ptr = 1'b0; auto_en = 1'b0;
        #1;
        check("reset_out_valid", 256'(out_valid), 256'h0);
        check("reset_ptr", 256'(ptr), 256'h0);
        check("reset_out_data", 256'(out_data), 256'h0);
        check("reset_in_ready", 256'(in_ready), 256'h1);
        check("reset_all_full", 256'(all_full), 256'h0);
        m_full = '0; m_ptr = 0; s_valid = '0; s_ptr = 0; s_ready = 1'b1; hold_v = 1'b0;
        for (int k = 0; k < 8; k++) exp_q[k].delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compare handshake outputs with the model, and each held word with its queue head.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("in_ready", 256'(in_ready), 256'(s_ready));
            check("out_valid", 256'(out_valid), 256'(s_valid));
            check("ptr", 256'(ptr), 256'(s_ptr));
            check("all_full", 256'(all_full), 256'(s_valid == 8'hFF));
            for (int k = 0; k < 8; k++) begin
                if (out_valid[k]) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL lane%0d_unexpected: got %0h expected no word", k, lane(k));
                    end else begin
                        check($sformatf("lane%0d_data", k), 256'(lane(k)), 256'(exp_q[k][0]));
                        if (out_ack[k]) void'(exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bit           v;
        logic [2:0]   sel;
        logic [W-1:0] d;
        bit           au;

        do_reset();

        // Indexed write to lane 5, then ack.
        drive(1'b1, 3'd5, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00);
        idle(1'b0, 8'h00);
        #1;
        check("idx_out_valid", 256'(out_valid), 256'h20);
        check("idx_lane5", 256'(lane(5)), 256'hDEADBEEF);
        idle(1'b0, 8'h20);
        idle(1'b0, 8'h00);
        #1;
        check("idx_after_ack", 256'(out_valid), 256'h00);

        // Backpressure on lane 2, released by a same-cycle ack.
        drive(1'b1, 3'd2, 32'h1111_2222, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 3'd2, 32'h3333_4444, 1'b0, 1'b0, 8'h00);
        #1;
        check("bp_in_ready_low", 256'(in_ready), 256'h0);
        check("bp_lane2_held", 256'(lane(2)), 256'h1111_2222);
        drive(1'b1, 3'd2, 32'h3333_4444, 1'b0, 1'b0, 8'h04);
        #1;
        check("bp_in_ready_ack", 256'(in_ready), 256'h1);
        idle(1'b0, 8'h00);
        #1;
        check("bp_valid_stays", 256'(out_valid[2]), 256'h1);
        check("bp_lane2_new", 256'(lane(2)), 256'h3333_4444);
        idle(1'b0, 8'h04);

        // Auto mode wrap: nine words with every lane acked each cycle.
        idle(1'b1, 8'hFF);
        for (int i = 0; i < 9; i++) drive(1'b1, 3'd0, W'(i), 1'b1, 1'b0, 8'hFF);
        idle(1'b0, 8'hFF);
        #1;
        check("wrap_lane0", 256'(lane(0)), 256'h8);
        check("wrap_out_valid", 256'(out_valid), 256'h01);
        check("wrap_ptr", 256'(ptr), 256'h1);

        // Pointer clear in the same cycle as an accept.
        idle(1'b1, 8'hFF);
        for (int i = 0; i < 6; i++) drive(1'b1, 3'd0, W'(32'h50 + i), 1'b1, 1'b0, 8'hFF);
        idle(1'b0, 8'hFF);
        #1;
        check("clr_ptr_before", 256'(ptr), 256'h6);
        drive(1'b1, 3'd0, 32'h5A5A_5A5A, 1'b1, 1'b1, 8'h00);
        idle(1'b0, 8'h00);
        #1;
        check("clr_ptr_after", 256'(ptr), 256'h0);
        check("clr_out_valid", 256'(out_valid), 256'h40);
        check("clr_lane6", 256'(lane(6)), 256'h5A5A_5A5A);
        idle(1'b0, 8'h40);

        // Fill all lanes without acks; ninth word waits for lane 0.
        idle(1'b1, 8'hFF);
        for (int i = 0; i < 8; i++) drive(1'b1, 3'd0, W'(32'h100 + i), 1'b1, 1'b0, 8'h00);
        drive(1'b1, 3'd0, 32'h200, 1'b1, 1'b0, 8'h00);
        #1;
        check("fill_all_full", 256'(all_full), 256'h1);
        check("fill_in_ready", 256'(in_ready), 256'h0);
        check("fill_ptr", 256'(ptr), 256'h0);
        drive(1'b1, 3'd0, 32'h200, 1'b1, 1'b0, 8'h00);
        drive(1'b1, 3'd0, 32'h200, 1'b1, 1'b0, 8'h01);
        #1;
        check("fill_ack0_ready", 256'(in_ready), 256'h1);
        idle(1'b0, 8'h00);
        #1;
        check("fill_lane0_new", 256'(lane(0)), 256'h200);
        check("fill_ptr_next", 256'(ptr), 256'h1);
        idle(1'b0, 8'hFF);

        // Randomised traffic with a reset in the middle.
        v = 1'b0; sel = '0; d = '0; au = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if (!hold_v) begin
                v   = ($urandom_range(0, 99) < 70);
                sel = 3'($urandom);
                d   = W'($urandom);
                au  = ((i / 150) % 2 == 1);
            end
            drive(v, sel, d, au, ($urandom_range(0, 19) == 0), 8'($urandom) & 8'($urandom));
        end
        idle(1'b0, 8'h00);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
